lif_neuron_multi: RTL

//  Parametrised next-generation leaky integrate-and-fire neuron: N_SYN weighted synapse inputs,

---
 rtl/lif_pkg.sv | 33 +++
 rtl/lif_cfg_chain.sv | 58 +++++
 rtl/lif_neuron_multi.sv | 91 +++++++++
 3 files changed

// File: rtl/lif_pkg.sv
// rtl/lif_pkg.sv - shared sizing, field offsets and saturation helper for the LIF neuron
package lif_pkg;

  // Total configuration bits: N_SYN weights, threshold, leak shift, refractory count
  function automatic int cfg_bits(input int width, input int n_syn, input int leak_w, input int ref_w);
    return n_syn * width + width + leak_w + ref_w;
  endfunction

  // Field LSB positions inside the chain, layout MSB..LSB = {w[N-1]..w[0], thresh, leak, refrac}
  function automatic int refrac_lsb();
    return 0;
  endfunction

  function automatic int leak_lsb(input int ref_w);
    return ref_w;
  endfunction

  function automatic int thresh_lsb(input int leak_w, input int ref_w);
    return ref_w + leak_w;
  endfunction

  function automatic int w_lsb(input int width, input int leak_w, input int ref_w);
    return ref_w + leak_w + width;
  endfunction

  // Clamp an unsigned sum to the largest w-bit value
  function automatic logic [31:0] sat_u(input logic [31:0] s, input int w);
    logic [31:0] m;
    m = (32'd1 << w) - 32'd1;
    return (s > m) ? m : s;
  endfunction

endpackage

// File: rtl/lif_cfg_chain.sv
// rtl/lif_cfg_chain.sv - serial config shift chain, set_vars fall detect and shadow registers
module lif_cfg_chain
  import lif_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int N_SYN  = 4,
  parameter int LEAK_W = 3,
  parameter int REF_W  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     set_vars,
  input  logic                     cfg_d,
  output logic [N_SYN*WIDTH-1:0]   w_bus,
  output logic [WIDTH-1:0]         thresh,
  output logic [LEAK_W-1:0]        leak,
  output logic [REF_W-1:0]         refrac,
  output logic                     commit
);

  localparam int CB     = cfg_bits(WIDTH, N_SYN, LEAK_W, REF_W);
  localparam int REF_L  = refrac_lsb();
  localparam int LEAK_L = leak_lsb(REF_W);
  localparam int TH_L   = thresh_lsb(LEAK_W, REF_W);
  localparam int W_L    = w_lsb(WIDTH, LEAK_W, REF_W);

  // Defaults: zero weights, all-ones threshold, no leak, no refractory
  localparam logic [CB-1:0] SHADOW_RST = CB'({WIDTH{1'b1}}) << TH_L;

  logic [CB-1:0] chain;
  logic [CB-1:0] shadow;
  logic          set_d;

  assign commit = set_d & ~set_vars;

  // Shift config in MSB-first while loading; remember last set_vars for the fall detect
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chain <= '0;
      set_d <= 1'b0;
    end else begin
      set_d <= set_vars;
      if (set_vars) chain <= {chain[CB-2:0], cfg_d};
    end
  end

  // Shadow copy only changes on the first cycle after a load ends
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) shadow <= SHADOW_RST;
    else if (commit) shadow <= chain;
  end

  assign w_bus  = shadow[W_L +: N_SYN*WIDTH];
  assign thresh = shadow[TH_L +: WIDTH];
  assign leak   = shadow[LEAK_L +: LEAK_W];
  assign refrac = shadow[REF_L +: REF_W];

endmodule

// File: rtl/lif_neuron_multi.sv
// rtl/lif_neuron_multi.sv - leaky integrate-and-fire neuron with N_SYN weighted synapses
module lif_neuron_multi
  import lif_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int N_SYN  = 4,
  parameter int LEAK_W = 3,
  parameter int REF_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_vars,
  input  logic             cfg_d,
  input  logic [N_SYN-1:0] syn,
  output logic             axon,
  output logic [WIDTH-1:0] V,
  output logic             refr
);

  localparam int SUM_W = WIDTH + $clog2(N_SYN + 1);

  logic [N_SYN*WIDTH-1:0] w_bus;
  logic [WIDTH-1:0]       thresh;
  logic [LEAK_W-1:0]      leak;
  logic [REF_W-1:0]       refrac;
  logic                   commit;
  logic [REF_W-1:0]       ref_cnt;
  logic [WIDTH-1:0]       leaked;
  logic [SUM_W-1:0]       sum;
  logic [WIDTH-1:0]       sat;
  logic                   fire;
  logic                   hold;

  lif_cfg_chain #(
    .WIDTH (WIDTH),
    .N_SYN (N_SYN),
    .LEAK_W(LEAK_W),
    .REF_W (REF_W)
  ) u_cfg (
    .clk     (clk),
    .rst     (rst),
    .set_vars(set_vars),
    .cfg_d   (cfg_d),
    .w_bus   (w_bus),
    .thresh  (thresh),
    .leak    (leak),
    .refrac  (refrac),
    .commit  (commit)
  );

  // Neuron is frozen during load and during the commit cycle
  assign hold = set_vars | commit;

  // Leak, accumulate active synapse weights, clamp and compare against threshold
  always_comb begin
    leaked = (leak == '0) ? V : (V - (V >> leak));
    sum    = SUM_W'(leaked);
    for (int i = 0; i < N_SYN; i++) begin
      if (syn[i]) sum = sum + SUM_W'(w_bus[i*WIDTH +: WIDTH]);
    end
    sat  = WIDTH'(sat_u(32'(sum), WIDTH));
    fire = (sat >= thresh);
  end

  // Membrane, spike and refractory counter update
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      V       <= '0;
      axon    <= 1'b0;
      ref_cnt <= '0;
    end else if (hold) begin
      V       <= '0;
      axon    <= 1'b0;
      ref_cnt <= '0;
    end else if (ref_cnt != '0) begin
      V       <= '0;
      axon    <= 1'b0;
      ref_cnt <= ref_cnt - 1'b1;
    end else if (fire) begin
      V       <= '0;
      axon    <= 1'b1;
      ref_cnt <= refrac;
    end else begin
      V       <= sat;
      axon    <= 1'b0;
    end
  end

  assign refr = (ref_cnt != '0);

endmodule
